// File: rtl/serializer_pkg.sv
// Shared types and helpers for the parallel-in/serial-out transmitter.
// SERIALIZER_PARITY_EN adds the PARITY state used for a trailing even-parity beat.
package serializer_pkg;

  localparam int DW_DEFAULT = 64;

  function automatic int cnt_width(input int dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

  localparam int CW = cnt_width(DW_DEFAULT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
`ifdef SERIALIZER_PARITY_EN
    SHIFT  = 2'd1,
    PARITY = 2'd2
`else
    SHIFT  = 2'd1
`endif
  } state_e;

endpackage

// File: rtl/serializer_if.sv
// Parallel word handshake plus serial strobe/data bundle for the serializer.
// Handshake: a word transfers on a posedge where in_valid & in_ready are both 1;
// in_valid must not depend on in_ready, and in must stay stable while in_valid is high.
interface serializer_if #(
    parameter int DW = 64
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in;
    logic          stall;
    logic          en;
    logic          out;
    logic          busy;

    modport master (
        output in_valid,
        output in,
        output stall,
        input  in_ready,
        input  en,
        input  out,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in,
        input  stall,
        output in_ready,
        output en,
        output out,
        output busy
    );
endinterface

// File: rtl/serializer_ctrl.sv
// Frame FSM, beat counter and input handshake of the serializer.
// With SERIALIZER_PARITY_EN a PARITY beat follows the DW data beats.
module serializer_ctrl
    import serializer_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   in_valid_i,
    input  logic   stall_i,
    output logic   in_ready_o,
    output logic   accept_o,
    output logic   en_o,
    output logic   busy_o,
    output state_e state_o
);

    localparam int             CWL  = cnt_width(DW);
    localparam logic [CWL-1:0] LAST = CWL'(DW - 1);

    state_e         state_q;
    logic [CWL-1:0] cnt_q;
    logic           active;
    logic           data_last;
    logic           frame_end;

    assign active    = (state_q != IDLE);
    assign en_o      = active & ~stall_i;
    assign data_last = en_o & (state_q == SHIFT) & (cnt_q == LAST);

`ifdef SERIALIZER_PARITY_EN
    assign frame_end = en_o & (state_q == PARITY);
`else
    assign frame_end = data_last;
`endif

    // A stalled last beat is not a last beat, so it cannot accept either.
    assign in_ready_o = ~rst & (~active | frame_end);
    assign accept_o   = in_valid_i & in_ready_o;
    assign busy_o     = active;
    assign state_o    = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else if (accept_o) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
        end else if (en_o) begin
            case (state_q)
                SHIFT: begin
                    if (data_last) begin
                        cnt_q   <= '0;
`ifdef SERIALIZER_PARITY_EN
                        state_q <= PARITY;
`else
                        state_q <= IDLE;
`endif
                    end else begin
                        cnt_q <= cnt_q + CWL'(1);
                    end
                end
`ifdef SERIALIZER_PARITY_EN
                PARITY: state_q <= IDLE;
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/serializer.sv
// Parallel-in, serial-out transmitter: MSB-first bits with an enable strobe.
// Optional even-parity trailer beat when SERIALIZER_PARITY_EN is defined.
module serializer
    import serializer_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic        clk,
    input  logic        rst,
    serializer_if.slave bus,
    output state_e      state_o
);

    logic          accept;
    logic          en;
    logic          busy;
    logic          ready;
    state_e        state;
    logic [DW-1:0] sreg_q;
    logic [DW-1:0] sreg_d;
    logic          out_bit;

    serializer_ctrl #(
        .DW(DW)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (bus.in_valid),
        .stall_i    (bus.stall),
        .in_ready_o (ready),
        .accept_o   (accept),
        .en_o       (en),
        .busy_o     (busy),
        .state_o    (state)
    );

    always_comb begin
        sreg_d = sreg_q;
        if (accept) begin
            sreg_d = bus.in;
        end else if (en && (state == SHIFT)) begin
            sreg_d = {sreg_q[DW-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

`ifdef SERIALIZER_PARITY_EN
    logic par_q;
    logic par_d;

    assign par_d = accept ? ^bus.in : par_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    // The MSB holds the bit on the wire while stalled, so out is stable for free.
    always_comb begin
        out_bit = 1'b0;
        case (state)
            SHIFT:  out_bit = sreg_q[DW-1];
`ifdef SERIALIZER_PARITY_EN
            PARITY: out_bit = par_q;
`endif
            default: out_bit = 1'b0;
        endcase
    end

    assign bus.in_ready = ready;
    assign bus.en       = en;
    assign bus.out      = out_bit;
    assign bus.busy     = busy;
    assign state_o      = state;

endmodule

// File: tb/tb_serializer.sv
// Directed bench for serializer at DW=8 with a bit-level expected queue and a SIPO model.
// Frame length follows SERIALIZER_PARITY_EN (DW or DW+1 beats).
module tb_serializer;
  import serializer_pkg::*;

  localparam int DW = 8;
`ifdef SERIALIZER_PARITY_EN
  localparam int FL = DW + 1;
`else
  localparam int FL = DW;
`endif

  logic   clk;
  logic   rst;
  state_e state;

  serializer_if #(.DW(DW)) bus ();

  serializer #(.DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state)
  );

  logic [0:0]    exp_q[$];
  int            vectors;
  int            errors;
  logic          s_en, s_out, s_busy, s_ready;
  state_e        s_state;
  logic [FL-1:0] sipo;
  logic [DW-1:0] w;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [FL-1:0] frame_of(input logic [DW-1:0] word);
`ifdef SERIALIZER_PARITY_EN
    return {word, ^word};
`else
    return word;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] word);
    logic [FL-1:0] f;
    f = frame_of(word);
    for (int i = FL - 1; i >= 0; i--) exp_q.push_back(f[i]);
  endtask

  // Sample at negedge, score any serial beat, then advance past the next posedge.
  task automatic tick();
    logic [0:0] e;
    @(negedge clk);
    s_en    = bus.en;
    s_out   = bus.out;
    s_busy  = bus.busy;
    s_ready = bus.in_ready;
    s_state = state;
    if (s_en) begin
      if (exp_q.size() == 0) begin
        check("en_with_empty_queue", s_en, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("serial_bit", s_out, e);
        sipo = {sipo[FL-2:0], s_out};
      end
    end
    @(posedge clk);
    #1;
  endtask

  // driver: present one word and hold it for the accepting cycle
  task automatic load(input logic [DW-1:0] word);
    push_word(word);
    bus.in_valid = 1'b1;
    bus.in       = word;
    tick();
    check("load_ready", s_ready, 1'b1);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    vectors      = 0;
    errors       = 0;
    sipo         = '0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in       = '0;
    bus.stall    = 1'b0;

    // reset held two cycles while idle
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_ready", s_ready, 1'b0);
      check("rst_en", s_en, 1'b0);
      check("rst_out", s_out, 1'b0);
    end
    rst = 1'b0;
    tick();
    check("post_rst_ready", s_ready, 1'b1);
    check("post_rst_busy", s_busy, 1'b0);
    check("post_rst_state", s_state, IDLE);

    // stall has no effect while idle
    bus.stall = 1'b1;
    tick();
    check("idle_stall_ready", s_ready, 1'b1);
    check("idle_stall_en", s_en, 1'b0);
    bus.stall = 1'b0;

    // single frame 0xA5
    sipo = '0;
    load(8'hA5);
    for (int i = 0; i < FL; i++) begin
      tick();
      check("a5_en", s_en, 1'b1);
      check("a5_busy", s_busy, 1'b1);
    end
    tick();
    check("a5_end_en", s_en, 1'b0);
    check("a5_end_busy", s_busy, 1'b0);
    check("a5_sipo", sipo, frame_of(8'hA5));

    // 0x3C with stall on beats 3-4
    sipo = '0;
    w    = 8'h3C;
    load(w);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("3c_en_pre", s_en, 1'b1);
    end
    bus.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("3c_stall_en", s_en, 1'b0);
      check("3c_stall_out", s_out, w[DW-3]);
      check("3c_stall_busy", s_busy, 1'b1);
    end
    bus.stall = 1'b0;
    for (int i = 0; i < FL - 2; i++) begin
      tick();
      check("3c_en_post", s_en, 1'b1);
    end
    tick();
    check("3c_end_en", s_en, 1'b0);
    check("3c_sipo", sipo, frame_of(w));

    // back-to-back 0xFF then 0x00 with in_valid held
    load(8'hFF);
    push_word(8'h00);
    bus.in_valid = 1'b1;
    bus.in       = 8'h00;
    for (int i = 0; i < 2 * FL; i++) begin
      tick();
      check("b2b_en", s_en, 1'b1);
      if (i < FL - 1) check("b2b_not_ready", s_ready, 1'b0);
      if (i == FL - 1) begin
        check("b2b_ready_last", s_ready, 1'b1);
        bus.in_valid = 1'b0;
      end
    end
    tick();
    check("b2b_end_en", s_en, 1'b0);
    check("b2b_queue_empty", exp_q.size(), 0);

    // stall coinciding with in_valid on the last beat delays the accept
    sipo = '0;
    load(8'h5A);
    for (int i = 0; i < FL - 1; i++) tick();
    push_word(8'h96);
    bus.in_valid = 1'b1;
    bus.in       = 8'h96;
    bus.stall    = 1'b1;
    tick();
    check("last_stall_en", s_en, 1'b0);
    check("last_stall_ready", s_ready, 1'b0);
    bus.stall = 1'b0;
    tick();
    check("last_retry_en", s_en, 1'b1);
    check("last_retry_ready", s_ready, 1'b1);
    bus.in_valid = 1'b0;
    check("5a_sipo", sipo, frame_of(8'h5A));
    for (int i = 0; i < FL; i++) begin
      tick();
      check("96_en", s_en, 1'b1);
    end
    check("96_sipo", sipo, frame_of(8'h96));
    tick();
    check("96_end_busy", s_busy, 1'b0);

    // reset mid-frame on beat 4 of 0x81
    load(8'h81);
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    check("rst_beat4_en", s_en, 1'b1);
    tick();
    check("rst_mid_en", s_en, 1'b0);
    check("rst_mid_busy", s_busy, 1'b0);
    check("rst_mid_out", s_out, 1'b0);
    check("rst_mid_ready", s_ready, 1'b0);
    rst = 1'b0;
    check("rst_dropped_bits", exp_q.size(), FL - 4);
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_after_en", s_en, 1'b0);
      check("rst_after_ready", s_ready, 1'b1);
    end

`ifdef SERIALIZER_PARITY_EN
    // parity trailer: 0x07 -> 1, 0x03 -> 0, back-to-back contiguous
    load(8'h07);
    push_word(8'h03);
    bus.in_valid = 1'b1;
    bus.in       = 8'h03;
    for (int i = 0; i < 2 * FL; i++) begin
      tick();
      check("par_en", s_en, 1'b1);
      if (i == FL - 1) begin
        check("par_07", s_out, 1'b1);
        check("par_ready", s_ready, 1'b1);
        bus.in_valid = 1'b0;
      end
      if (i == 2 * FL - 1) check("par_03", s_out, 1'b0);
    end
    tick();
    check("par_end_en", s_en, 1'b0);
`endif

    // randomized single frames
    for (int n = 0; n < 4; n++) begin
      sipo = '0;
      w    = DW'($urandom_range(0, 255));
      load(w);
      for (int i = 0; i < FL; i++) tick();
      check("rand_sipo", sipo, frame_of(w));
      tick();
      check("rand_end_en", s_en, 1'b0);
    end

    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
